// File: rtl/inert_pkg.sv
// Shared definitions for the inertial-sensor SPI responder: FSM states and the
// register map also used by the master-side interface.
package inert_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CMD    = 2'd1,
    DATA   = 2'd2,
    COMMIT = 2'd3
  } resp_state_t;

  localparam logic [6:0] REG_INT1_CTRL = 7'h0D;
  localparam logic [6:0] REG_WHO       = 7'h0F;
  localparam logic [6:0] REG_CTRL1     = 7'h10;
  localparam logic [6:0] REG_CTRL2     = 7'h11;
  localparam logic [6:0] REG_CTRL6     = 7'h14;
  localparam logic [6:0] REG_PTCH_L    = 7'h22;
  localparam logic [6:0] REG_PTCH_H    = 7'h23;
  localparam logic [6:0] REG_ROLL_L    = 7'h24;
  localparam logic [6:0] REG_ROLL_H    = 7'h25;
  localparam logic [6:0] REG_YAW_L     = 7'h26;
  localparam logic [6:0] REG_YAW_H     = 7'h27;
  localparam logic [6:0] REG_AX_L      = 7'h28;
  localparam logic [6:0] REG_AX_H      = 7'h29;
  localparam logic [6:0] REG_AY_L      = 7'h2A;
  localparam logic [6:0] REG_AY_H      = 7'h2B;

  localparam logic [4:0] FRAME_BITS = 5'd16;

endpackage

// File: rtl/spi_slv16.sv
// 16-bit SPI mode-0 slave front end: input synchronizers, SCLK/SS_n edge detect,
// bit counter, command/write capture and MSB-first read-byte shifter.
module spi_slv16
  import inert_pkg::*;
#(
  parameter int SYNC_STG = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ss_n,
  input  logic       sclk,
  input  logic       mosi,
  input  logic [7:0] tx_data,
  output logic       miso,
  output logic [7:0] cmd,
  output logic [7:0] wr_data,
  output logic       frame_start,
  output logic       addr_vld,
  output logic       frame_ok,
  output logic       frame_abort
);

  logic [SYNC_STG-1:0] ss_sync;
  logic [SYNC_STG-1:0] sclk_sync;
  logic [SYNC_STG-1:0] mosi_sync;
  logic                ss_s, sclk_s, mosi_s;
  logic                ss_d, sclk_d;
  logic                sclk_rise, sclk_fall, ss_fall, ss_rise;
  logic [4:0]          cnt;
  logic [7:0]          rx;
  logic [7:0]          tx;
  logic                tx_act;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ss_sync   <= '1;
      sclk_sync <= '0;
      mosi_sync <= '0;
      ss_d      <= 1'b1;
      sclk_d    <= 1'b0;
    end else begin
      ss_sync   <= {ss_sync[SYNC_STG-2:0], ss_n};
      sclk_sync <= {sclk_sync[SYNC_STG-2:0], sclk};
      mosi_sync <= {mosi_sync[SYNC_STG-2:0], mosi};
      ss_d      <= ss_s;
      sclk_d    <= sclk_s;
    end
  end

  assign ss_s   = ss_sync[SYNC_STG-1];
  assign sclk_s = sclk_sync[SYNC_STG-1];
  assign mosi_s = mosi_sync[SYNC_STG-1];

  // SCLK edges only count while selected, so stray clocks between frames are ignored.
  assign sclk_rise = sclk_s & ~sclk_d & ~ss_s;
  assign sclk_fall = ~sclk_s & sclk_d & ~ss_s;
  assign ss_fall   = ss_d & ~ss_s;
  assign ss_rise   = ~ss_d & ss_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      rx          <= '0;
      cmd         <= '0;
      wr_data     <= '0;
      frame_start <= 1'b0;
      addr_vld    <= 1'b0;
      frame_ok    <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      frame_start <= ss_fall;
      addr_vld    <= sclk_rise && (cnt == 5'd7);
      frame_ok    <= ss_rise && (cnt == FRAME_BITS);
      frame_abort <= ss_rise && (cnt != FRAME_BITS);
      if (ss_fall) begin
        cnt <= '0;
      end else if (sclk_rise && (cnt != 5'd31)) begin
        cnt <= cnt + 5'd1;
      end
      if (sclk_rise) begin
        rx <= {rx[6:0], mosi_s};
      end
      if (sclk_rise && (cnt == 5'd7)) begin
        cmd <= {rx[6:0], mosi_s};
      end
      if (ss_rise) begin
        wr_data <= rx;
      end
    end
  end

  // Read byte is loaded on the 8th fall and shifted on falls 9..15.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx     <= '0;
      tx_act <= 1'b0;
    end else if (ss_fall || ss_rise) begin
      tx     <= '0;
      tx_act <= 1'b0;
    end else if (sclk_fall && (cnt == 5'd8)) begin
      tx     <= tx_data;
      tx_act <= 1'b1;
    end else if (sclk_fall && (cnt >= 5'd9) && (cnt <= 5'd15)) begin
      tx <= {tx[6:0], 1'b0};
    end
  end

  assign miso = tx_act & tx[7];

endmodule

// File: rtl/inert_spi_resp.sv
// Inertial-sensor SPI responder: config registers, sample registers, INT and the
// frame FSM. Optional coherent-burst sample holding under INERT_RESP_HOLD_EN.
module inert_spi_resp
  import inert_pkg::*;
#(
  parameter logic [7:0] WHO_AM_I = 8'h6A,
  parameter int         SYNC_STG = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        SS_n,
  input  logic        SCLK,
  input  logic        MOSI,
  output logic        MISO,
  output logic        INT,
  input  logic        smpl_vld,
  input  logic [15:0] ptch_in,
  input  logic [15:0] roll_in,
  input  logic [15:0] yaw_in,
  input  logic [15:0] ax_in,
  input  logic [15:0] ay_in,
  output logic        cfg_done,
  output logic [1:0]  fsm_state
);

  // Handshake: smpl_vld is a one-clk strobe with no back-pressure; the *_in buses
  // are only sampled in the cycle smpl_vld is high.

  resp_state_t state, state_nxt;
  logic [7:0]  cmd, wr_data, rd_data;
  logic        frame_start, addr_vld, frame_ok, frame_abort;
  logic [6:0]  addr;
  logic        commit, wr_en, rd_clr;
  logic [7:0]  int1_ctrl, ctrl1, ctrl2, ctrl6;
  logic [3:0]  wr_seen;
  logic [15:0] ptch_q, roll_q, yaw_q, ax_q, ay_q;
  logic [79:0] in_bus, load_src;
  logic        load, cap_q, int_q;

  spi_slv16 #(.SYNC_STG(SYNC_STG)) u_slv (
    .clk         (clk),
    .rst_n       (rst_n),
    .ss_n        (SS_n),
    .sclk        (SCLK),
    .mosi        (MOSI),
    .tx_data     (rd_data),
    .miso        (MISO),
    .cmd         (cmd),
    .wr_data     (wr_data),
    .frame_start (frame_start),
    .addr_vld    (addr_vld),
    .frame_ok    (frame_ok),
    .frame_abort (frame_abort)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (frame_start) state_nxt = CMD;
      CMD: begin
        if (frame_abort)   state_nxt = IDLE;
        else if (addr_vld) state_nxt = DATA;
      end
      DATA: begin
        if (frame_ok)         state_nxt = COMMIT;
        else if (frame_abort) state_nxt = IDLE;
      end
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign fsm_state = state;
  assign addr      = cmd[6:0];
  assign commit    = (state == COMMIT);
  assign wr_en     = commit & ~cmd[7];
  assign rd_clr    = commit & cmd[7] & (addr == REG_AY_H);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      int1_ctrl <= '0;
      ctrl1     <= '0;
      ctrl2     <= '0;
      ctrl6     <= '0;
      wr_seen   <= '0;
    end else if (wr_en) begin
      case (addr)
        REG_INT1_CTRL: begin int1_ctrl <= wr_data; wr_seen[0] <= 1'b1; end
        REG_CTRL1:     begin ctrl1     <= wr_data; wr_seen[1] <= 1'b1; end
        REG_CTRL2:     begin ctrl2     <= wr_data; wr_seen[2] <= 1'b1; end
        REG_CTRL6:     begin ctrl6     <= wr_data; wr_seen[3] <= 1'b1; end
        default: ;
      endcase
    end
  end

  assign cfg_done = &wr_seen;

  always_comb begin
    rd_data = 8'h00;
    case (addr)
      REG_INT1_CTRL: rd_data = int1_ctrl;
      REG_WHO:       rd_data = WHO_AM_I;
      REG_CTRL1:     rd_data = ctrl1;
      REG_CTRL2:     rd_data = ctrl2;
      REG_CTRL6:     rd_data = ctrl6;
      REG_PTCH_L:    rd_data = ptch_q[7:0];
      REG_PTCH_H:    rd_data = ptch_q[15:8];
      REG_ROLL_L:    rd_data = roll_q[7:0];
      REG_ROLL_H:    rd_data = roll_q[15:8];
      REG_YAW_L:     rd_data = yaw_q[7:0];
      REG_YAW_H:     rd_data = yaw_q[15:8];
      REG_AX_L:      rd_data = ax_q[7:0];
      REG_AX_H:      rd_data = ax_q[15:8];
      REG_AY_L:      rd_data = ay_q[7:0];
      REG_AY_H:      rd_data = ay_q[15:8];
      default:       rd_data = 8'h00;
    endcase
  end

  assign in_bus = {ptch_in, roll_in, yaw_in, ax_in, ay_in};

`ifdef INERT_RESP_HOLD_EN
  logic        hold, pend;
  logic [79:0] pend_buf;

  // Hold also covers the cycle between capture and INT rising, so no sample slips in.
  assign hold     = int_q | (cap_q & int1_ctrl[1]) | (state != IDLE);
  assign load     = ~hold & (smpl_vld | pend);
  assign load_src = smpl_vld ? in_bus : pend_buf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend     <= 1'b0;
      pend_buf <= '0;
    end else if (smpl_vld && hold) begin
      pend     <= 1'b1;
      pend_buf <= in_bus;
    end else if (!hold) begin
      pend <= 1'b0;
    end
  end
`else
  assign load     = smpl_vld;
  assign load_src = in_bus;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptch_q <= '0;
      roll_q <= '0;
      yaw_q  <= '0;
      ax_q   <= '0;
      ay_q   <= '0;
      cap_q  <= 1'b0;
    end else begin
      cap_q <= load;
      if (load) {ptch_q, roll_q, yaw_q, ax_q, ay_q} <= load_src;
    end
  end

  // A capture landing in the same cycle as the AY_H clear keeps INT set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       int_q <= 1'b0;
    else if (cap_q && int1_ctrl[1])   int_q <= 1'b1;
    else if (rd_clr)                  int_q <= 1'b0;
  end

  assign INT = int_q;

endmodule

// File: tb/tb_inert_spi_resp.sv
// Self-checking bench for inert_spi_resp: SPI master tasks, read scoreboard and
// sample stimulus; honours INERT_RESP_HOLD_EN for the mid-burst case.
module tb_inert_spi_resp;
  localparam int HP = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ss_n = 1'b1;
  logic        sclk = 1'b0;
  logic        mosi = 1'b0;
  logic        smpl_vld = 1'b0;
  logic [15:0] ptch_in = '0, roll_in = '0, yaw_in = '0, ax_in = '0, ay_in = '0;
  logic        miso, int_o, cfg_done;
  logic [1:0]  fsm_state;

  int          n_checks = 0;
  int          n_fails = 0;
  logic [7:0]  exp_q[$];
  logic [79:0] model;

  always #5 clk = ~clk;

  inert_spi_resp dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .SS_n      (ss_n),
    .SCLK      (sclk),
    .MOSI      (mosi),
    .MISO      (miso),
    .INT       (int_o),
    .smpl_vld  (smpl_vld),
    .ptch_in   (ptch_in),
    .roll_in   (roll_in),
    .yaw_in    (yaw_in),
    .ax_in     (ax_in),
    .ay_in     (ay_in),
    .cfg_done  (cfg_done),
    .fsm_state (fsm_state)
  );

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input logic [6:0] a, input logic [79:0] s);
    logic [15:0] w;
    case (a)
      7'h22, 7'h23: w = s[79:64];
      7'h24, 7'h25: w = s[63:48];
      7'h26, 7'h27: w = s[47:32];
      7'h28, 7'h29: w = s[31:16];
      7'h2A, 7'h2B: w = s[15:0];
      default:      w = 16'h0000;
    endcase
    return a[0] ? w[15:8] : w[7:0];
  endfunction

  task automatic spi_xfer(input logic [15:0] word, input int nbits, output logic [7:0] rd);
    logic cmd_or;
    cmd_or = 1'b0;
    rd = 8'h00;
    check_eq("miso_idle", {15'h0, miso}, 16'h0);
    @(negedge clk) ss_n = 1'b0;
    repeat (6) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      mosi = (i < 16) ? word[15-i] : 1'b0;
      repeat (HP) @(negedge clk);
      if (i < 8) cmd_or = cmd_or | miso;
      else if (i < 16) rd = {rd[6:0], miso};
      sclk = 1'b1;
      repeat (HP) @(negedge clk);
      sclk = 1'b0;
    end
    repeat (HP) @(negedge clk);
    ss_n = 1'b1;
    mosi = 1'b0;
    repeat (8) @(negedge clk);
    if (nbits >= 8) check_eq("miso_cmd_phase", {15'h0, cmd_or}, 16'h0);
  endtask

  task automatic wr_reg(input logic [6:0] a, input logic [7:0] d);
    logic [7:0] dummy;
    spi_xfer({1'b0, a, d}, 16, dummy);
  endtask

  task automatic rd_chk(input string tag, input logic [6:0] a, input logic [7:0] exp);
    logic [7:0] got;
    exp_q.push_back(exp);
    spi_xfer({1'b1, a, 8'h00}, 16, got);
    check_eq(tag, {8'h00, got}, {8'h00, exp_q.pop_front()});
  endtask

  task automatic burst(input string tag, input int last, input logic [79:0] s);
    for (int a = 'h22; a <= last; a++) begin
      logic [6:0] aa;
      aa = a[6:0];
      rd_chk(tag, aa, exp_byte(aa, s));
    end
  endtask

  task automatic pulse_smp(input logic [79:0] s);
    @(negedge clk);
    {ptch_in, roll_in, yaw_in, ax_in, ay_in} = s;
    smpl_vld = 1'b1;
    @(negedge clk);
    smpl_vld = 1'b0;
    {ptch_in, roll_in, yaw_in, ax_in, ay_in} = {$urandom, $urandom, $urandom};
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [79:0] s1, s2, s3, s4;
    logic [15:0] w;
    logic [7:0]  dummy;

    // 1: reset state and config writes
    repeat (5) @(negedge clk);
    check_eq("rst_miso", {15'h0, miso}, 16'h0);
    check_eq("rst_int", {15'h0, int_o}, 16'h0);
    check_eq("rst_cfg_done", {15'h0, cfg_done}, 16'h0);
    check_eq("rst_state", {14'h0, fsm_state}, 16'h0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    rd_chk("rst_ctrl1", 7'h10, 8'h00);
    rd_chk("rst_ptch_l", 7'h22, 8'h00);
    wr_reg(7'h0D, 8'h02);
    wr_reg(7'h10, 8'h62);
    wr_reg(7'h11, 8'h62);
    check_eq("cfg_done_3of4", {15'h0, cfg_done}, 16'h0);
    wr_reg(7'h14, 8'h60);
    check_eq("cfg_done_4of4", {15'h0, cfg_done}, 16'h1);
    rd_chk("rd_int1", 7'h0D, 8'h02);
    rd_chk("rd_ctrl1", 7'h10, 8'h62);
    rd_chk("rd_ctrl2", 7'h11, 8'h62);
    rd_chk("rd_ctrl6", 7'h14, 8'h60);
    rd_chk("rd_who", 7'h0F, 8'h6A);
    wr_reg(7'h0F, 8'h55);
    rd_chk("who_ro", 7'h0F, 8'h6A);
    wr_reg(7'h22, 8'h77);
    rd_chk("data_ro", 7'h22, 8'h00);
    rd_chk("unmapped", 7'h40, 8'h00);
    check_eq("int_pre_smp", {15'h0, int_o}, 16'h0);

    // 2: first sample
    s1 = {16'h1234, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)};
    model = s1;
    pulse_smp(s1);
    check_eq("int_set", {15'h0, int_o}, 16'h1);
    rd_chk("ptch_l", 7'h22, 8'h34);
    rd_chk("ptch_h", 7'h23, 8'h12);
    check_eq("int_after_a3", {15'h0, int_o}, 16'h1);

    // 3: full burst, INT clears only after AY_H
    burst("burst1", 'h2A, model);
    check_eq("int_before_ab", {15'h0, int_o}, 16'h1);
    rd_chk("burst1_ab", 7'h2B, exp_byte(7'h2B, model));
    check_eq("int_after_ab", {15'h0, int_o}, 16'h0);

    // 4: aborted frames
    s2 = {16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 16'h5555};
    model = s2;
    pulse_smp(s2);
    check_eq("int_set2", {15'h0, int_o}, 16'h1);
    spi_xfer(16'h10AA, 10, dummy);
    rd_chk("short_wr", 7'h10, 8'h62);
    spi_xfer(16'h10AA, 17, dummy);
    rd_chk("long_wr", 7'h10, 8'h62);
    spi_xfer(16'hAB00, 12, dummy);
    check_eq("short_rd_no_clr", {15'h0, int_o}, 16'h1);
    spi_xfer(16'h10AA, 5, dummy);
    rd_chk("tiny_wr", 7'h10, 8'h62);
    check_eq("int_unchanged", {15'h0, int_o}, 16'h1);

    // 5: new sample mid-burst
    burst("burst2", 'h2A, model);
    s3 = {16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 16'hAAAA};
    pulse_smp(s3);
`ifdef INERT_RESP_HOLD_EN
    rd_chk("mid_ab_hold", 7'h2B, 8'h55);
    repeat (4) @(negedge clk);
    check_eq("int_reset_hold", {15'h0, int_o}, 16'h1);
`else
    rd_chk("mid_ab_nohold", 7'h2B, 8'hAA);
    check_eq("int_clr_nohold", {15'h0, int_o}, 16'h0);
`endif
    model = s3;
    burst("burst3", 'h2B, model);
    check_eq("int_after_b3", {15'h0, int_o}, 16'h0);

    // 6: reset in the middle of a read frame
    s4 = {$urandom, $urandom, 16'($urandom)};
    pulse_smp(s4);
    check_eq("int_set4", {15'h0, int_o}, 16'h1);
    w = 16'h8F00;
    @(negedge clk) ss_n = 1'b0;
    repeat (6) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      mosi = w[15-i];
      repeat (HP) @(negedge clk);
      sclk = 1'b1;
      repeat (HP) @(negedge clk);
      sclk = 1'b0;
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("midrst_miso", {15'h0, miso}, 16'h0);
    check_eq("midrst_int", {15'h0, int_o}, 16'h0);
    check_eq("midrst_cfg", {15'h0, cfg_done}, 16'h0);
    check_eq("midrst_state", {14'h0, fsm_state}, 16'h0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    ss_n = 1'b1;
    mosi = 1'b0;
    repeat (8) @(negedge clk);
    rd_chk("post_rst_who", 7'h0F, 8'h6A);
    rd_chk("post_rst_int1", 7'h0D, 8'h00);
    rd_chk("post_rst_ay_h", 7'h2B, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
